// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: reset level, stall hold vectors, FSM states.
package pipe_ctrl_pkg;
    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALLED = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    // The latest requesting stage holds itself and everything upstream.
    function automatic logic [5:0] stall_vec(input logic id, input logic ex, input logic mem);
        if (mem)     return STALL_MEM;
        else if (ex) return STALL_EX;
        else if (id) return STALL_ID;
        else         return STALL_NONE;
    endfunction
endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating performance counters: total stalled cycles and number of flush pulses.
module pipe_ctrl_perf
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_act_i,
    input  logic        flush_i,
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_count_o
);
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall_act_i && stall_cycles_q != 32'hFFFF_FFFF) stall_cycles_d = stall_cycles_q + 32'd1;
        if (flush_i && flush_count_q != 16'hFFFF)           flush_count_d  = flush_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            stall_cycles_q <= ZeroWord;
            flush_count_q  <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with a sticky stall watchdog.
// Define PIPE_CTRL_PERF_EN to add the stall-cycle and flush-count outputs.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        flush_req,
    input  logic [31:0] flush_pc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_count_o,
`endif
    output logic        timeout_o
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        to_q, to_d;
    logic        any_stall;

    assign any_stall = stallreq_id | stallreq_ex | stallreq_mem;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stall_o = STALL_NONE;
        if (rst != RstEnable && !flush_req && state_q != FLUSH)
            stall_o = stall_vec(stallreq_id, stallreq_ex, stallreq_mem);

        case (state_q)
            RUN, STALLED: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    pc_d    = flush_pc_i;
                end else if (any_stall) begin
                    state_d = STALLED;
                end else begin
                    state_d = RUN;
                end
            end
            // A request arriving during the pulse is dropped, not queued.
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase

        if (stall_o != STALL_NONE) cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        else                       cnt_d = 8'd0;
        to_d = to_q | ({24'd0, cnt_d} >= STALL_TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= RUN;
            pc_q    <= ZeroWord;
            cnt_q   <= 8'd0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign flush_o   = (state_q == FLUSH);
    assign new_pc_o  = pc_q;
    assign timeout_o = to_q;

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf u_perf (
        .clk            (clk),
        .rst            (rst),
        .stall_act_i    (stall_o != STALL_NONE),
        .flush_i        (flush_o),
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o)
    );
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations, then random traffic vs a model.
module tb_pipe_ctrl;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst, stallreq_id, stallreq_ex, stallreq_mem, flush_req;
    logic [31:0] flush_pc_i;
    logic [5:0]  stall_o;
    logic        flush_o, timeout_o;
    logic [31:0] new_pc_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_o;
    logic [15:0] flush_count_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit armed   = 1'b0;

    always #5 clk = ~clk;

    pipe_ctrl #(.STALL_TIMEOUT(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .flush_req    (flush_req),
        .flush_pc_i   (flush_pc_i),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .new_pc_o     (new_pc_o),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o),
`endif
        .timeout_o    (timeout_o)
    );

    // Model: a pending flush pulse, the captured target, the length of the current stall run,
    // and a sticky watchdog bit.
    bit          m_pend;
    logic [31:0] m_pc;
    int          m_run;
    bit          m_to;
    longint      m_stalls;
    int          m_flushes;

    function automatic logic [5:0] exp_stall();
        if (rst || flush_req || m_pend) return 6'd0;
        if (stallreq_mem) return 6'b011111;
        if (stallreq_ex)  return 6'b001111;
        if (stallreq_id)  return 6'b000111;
        return 6'd0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pend <= 1'b0; m_pc <= 32'd0; m_run <= 0; m_to <= 1'b0;
            m_stalls <= 0; m_flushes <= 0;
        end else begin
            m_pend <= !m_pend && flush_req;
            if (!m_pend && flush_req) m_pc <= flush_pc_i;
            if (exp_stall() != 6'd0) begin
                m_run    <= m_run + 1;
                m_stalls <= m_stalls + 1;
                if (m_run + 1 >= T) m_to <= 1'b1;
            end else begin
                m_run <= 0;
            end
            if (m_pend) m_flushes <= m_flushes + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("stall_o",   {26'd0, stall_o},   {26'd0, exp_stall()});
            chk("flush_o",   {31'd0, flush_o},   {31'd0, m_pend});
            chk("new_pc_o",  new_pc_o,           m_pc);
            chk("timeout_o", {31'd0, timeout_o}, {31'd0, m_to});
`ifdef PIPE_CTRL_PERF_EN
            chk("stall_cycles_o", stall_cycles_o, 32'(m_stalls));
            chk("flush_count_o",  {16'd0, flush_count_o}, 32'(m_flushes));
`endif
        end
    end

    // Inputs change 1 unit after a rising edge; literal checks settle 2 units later.
    task automatic drv(input logic r, input logic id, input logic ex, input logic mem,
                       input logic fl, input logic [31:0] pc);
        rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
        flush_req = fl; flush_pc_i = pc;
        #2;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        drv(1, 0, 0, 1, 0, 32'h0);
        chk("rst_stall_o", {26'd0, stall_o}, 32'd0);
        tick();
        armed = 1'b1;
        drv(1, 0, 0, 1, 0, 32'h0);
        chk("rst_flush_o", {31'd0, flush_o}, 32'd0);
        chk("rst_new_pc",  new_pc_o, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
        tick();
        drv(0, 0, 0, 1, 0, 32'h0);
        chk("rst_release_stall", {26'd0, stall_o}, 32'h1F);

        tick(); drv(0, 0, 0, 1, 1, 32'hBFC00380);
        chk("flush_over_stall", {26'd0, stall_o}, 32'd0);
        tick(); drv(0, 0, 0, 0, 0, 32'h0);
        chk("flush_pulse", {31'd0, flush_o}, 32'd1);
        chk("flush_pc",    new_pc_o, 32'hBFC00380);
        tick(); drv(0, 0, 0, 0, 0, 32'h0);
        chk("flush_one_cycle", {31'd0, flush_o}, 32'd0);
        chk("flush_pc_hold",   new_pc_o, 32'hBFC00380);

        tick(); drv(0, 0, 0, 0, 1, 32'h100);
        tick(); drv(0, 0, 0, 0, 1, 32'h200);
        chk("b2b_pulse", {31'd0, flush_o}, 32'd1);
        chk("b2b_pc",    new_pc_o, 32'h100);
        tick(); drv(0, 0, 0, 0, 0, 32'h0);
        chk("b2b_no_second", {31'd0, flush_o}, 32'd0);
        chk("b2b_pc_hold",   new_pc_o, 32'h100);

        for (int i = 0; i < 3; i++) begin
            tick(); drv(0, 1, 1, 0, 0, 32'h0);
            chk("prio_id_ex", {26'd0, stall_o}, 32'h0F);
        end
        tick(); drv(0, 0, 0, 0, 0, 32'h0);
        chk("prio_release", {26'd0, stall_o}, 32'd0);
        chk("wd_3cyc", {31'd0, timeout_o}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            tick(); drv(0, 0, 1, 0, 0, 32'h0);
            chk("wd_pre", {31'd0, timeout_o}, 32'd0);
        end
        tick(); drv(0, 0, 0, 0, 1, 32'h40);
        chk("wd_fire", {31'd0, timeout_o}, 32'd1);
        tick(); drv(0, 0, 0, 0, 0, 32'h0);
        chk("wd_after_flush", {31'd0, timeout_o}, 32'd1);
        chk("wd_flush_pulse", {31'd0, flush_o}, 32'd1);
        tick(); drv(1, 0, 0, 0, 0, 32'h0);
        tick(); drv(0, 0, 0, 0, 0, 32'h0);
        chk("wd_cleared", {31'd0, timeout_o}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            tick();
            drv($urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 50,
                $urandom_range(0, 99) < 40,
                $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 10,
                $urandom);
        end
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STALL_TIMEOUT, default 64, consecutive stalled cycles before timeout flag (range 2..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high (`RstEnable`).
REQ-004 SHALL have port stallreq_id  input  1  ID-stage stall request (load-use hazard).
REQ-005 SHALL have port stallreq_ex  input  1  EX-stage stall request (multi-cycle op).
REQ-006 SHALL have port stallreq_mem  input  1  MEM-stage stall request (data memory wait).
REQ-007 SHALL have port flush_req  input  1  exception/redirect flush request.
REQ-008 SHALL have port flush_pc_i  input  32  redirect target, sampled with flush_req.
REQ-009 SHALL have port stall_o  output  6  hold vector: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB.
REQ-010 SHALL have port flush_o  output  1  one-cycle flush pulse to all pipeline registers.
REQ-011 SHALL have port new_pc_o  output  32  redirect PC, valid while flush_o=1.
REQ-012 SHALL have port timeout_o  output  1  sticky stall-watchdog flag.

Function
REQ-013 SHALL implement FSM states RUN, STALLED, FLUSH.
REQ-014 stall_o SHALL be combinational from the current request inputs: stallreq_mem -> 6'b011111; else stallreq_ex -> 6'b001111; else stallreq_id -> 6'b000111; else 6'b000000 (latest stage wins).
REQ-015 stall_o SHALL be forced to 6'b000000 while flush_req=1 or state=FLUSH.
REQ-016 RUN -> STALLED when any stall request is set and flush_req=0; STALLED -> RUN when all stall requests are clear.
REQ-017 flush_req=1 in RUN or STALLED SHALL take priority over stall requests and move to FLUSH next cycle, latching flush_pc_i into new_pc_o.
REQ-018 In FLUSH, flush_o SHALL be 1 for exactly one cycle (registered, latency 1 from flush_req); next state RUN unconditionally.
REQ-019 flush_req asserted while in FLUSH SHALL be ignored (no second pulse, new_pc_o unchanged).
REQ-020 new_pc_o SHALL hold its last latched value outside FLUSH.
REQ-021 An 8-bit stall counter SHALL count consecutive cycles where stall_o is non-zero, clear on any cycle with stall_o=0, and saturate at 255.
REQ-022 timeout_o SHALL rise the cycle after the counter reaches STALL_TIMEOUT and remain 1 until reset, independent of later flushes.

Reset
REQ-023 rst=1 at a clock edge SHALL set state RUN, flush_o=0, new_pc_o=32'h0, stall counter=0, timeout_o=0, including in the middle of a flush or stall.
REQ-024 While rst=1, stall_o SHALL be 6'b000000 regardless of requests.

Configuration
REQ-025 With PIPE_CTRL_PERF_EN defined, the block SHALL add outputs stall_cycles_o (32-bit, total cycles with stall_o non-zero) and flush_count_o (16-bit, number of flush_o pulses), both saturating and cleared by rst.
REQ-026 Without PIPE_CTRL_PERF_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Stall vector encodings (STALL_NONE/ID/EX/MEM) and the FSM state encoding SHALL reside in the shared Defines.v alongside RstEnable/ZeroWord.
REQ-028 The block SHALL be flat except for an optional sub-module pipe_ctrl_perf holding the PIPE_CTRL_PERF_EN counters.

Verification
REQ-029 Reset: stallreq_mem=1 with rst=1 -> stall_o=0, flush_o=0, new_pc_o=0; deassert rst -> stall_o=6'b011111 same cycle.
REQ-030 Priority: stallreq_id=1, stallreq_ex=1 for 3 cycles -> stall_o=6'b001111 each cycle, state STALLED, return to RUN one cycle after release.
REQ-031 Flush over stall: stallreq_mem=1, flush_req=1, flush_pc_i=32'hBFC00380 -> stall_o=0 that cycle; next cycle flush_o=1, new_pc_o=32'hBFC00380; following cycle flush_o=0.
REQ-032 Back-to-back flush: flush_req held 2 cycles (targets 32'h100, 32'h200) -> exactly one flush_o pulse with new_pc_o=32'h100.
REQ-033 Watchdog: STALL_TIMEOUT=4, stallreq_ex=1 for 4 cycles -> timeout_o=1 in cycle 5, still 1 after a subsequent flush; a 3-cycle stall -> timeout_o stays 0.
REQ-034 Perf (PIPE_CTRL_PERF_EN): 10 stalled cycles plus 2 flushes -> stall_cycles_o=10, flush_count_o=2; rst mid-flush -> both 0, flush_o=0.
